// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage MIPS pipeline: per-stage enables,
// flushes and bubbles, halt-drain sequencing, data-memory watchdog and perf counters.
module pipe_stall_ctrl #(
   parameter int P_CNT_W       = 32,
   parameter int P_MEM_TIMEOUT = 255,
   parameter int P_DRAIN_CYC   = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_stall_lu,
   input  logic               i_branch_taken,
   input  logic               i_imem_busy,
   input  logic               i_dmem_busy,
   input  logic               i_halt,
   output logic               o_pc_en,
   output logic               o_ifid_en,
   output logic               o_ifid_flush,
   output logic               o_idex_en,
   output logic               o_idex_bubble,
   output logic               o_exmm_en,
   output logic               o_mmwb_en,
   output logic               o_mmwb_bubble,
   output logic               o_halted,
   output logic               o_timeout,
   output logic [P_CNT_W-1:0] o_stall_cnt,
   output logic [P_CNT_W-1:0] o_flush_cnt
);

   localparam int               DRN_W    = (P_DRAIN_CYC < 2) ? 1 : $clog2(P_DRAIN_CYC + 1);
   localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(P_DRAIN_CYC);
   localparam logic [15:0]      WD_MAX   = 16'(P_MEM_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t             state_q, state_d, state_eff;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic [15:0]        wd_q, wd_d;
   logic               timeout_q, timeout_d;
   logic [P_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [P_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic               halt_acc;
   logic               branch_fire;

   // Stage controls; the reset cycle is decoded as RUN so the pipe keeps moving.
   always_comb begin
      state_eff     = i_rst ? ST_RUN : state_q;
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_en     = 1'b1;
      o_idex_bubble = 1'b0;
      o_exmm_en     = 1'b1;
      o_mmwb_en     = 1'b1;
      o_mmwb_bubble = 1'b0;
      o_halted      = 1'b0;
      halt_acc      = 1'b0;
      branch_fire   = 1'b0;
      case (state_eff)
         ST_RUN: begin
            if (i_dmem_busy) begin
               o_pc_en       = 1'b0;
               o_ifid_en     = 1'b0;
               o_idex_en     = 1'b0;
               o_exmm_en     = 1'b0;
               o_mmwb_bubble = 1'b1;
            end else if (i_branch_taken) begin
               o_ifid_flush  = 1'b1;
               o_idex_bubble = 1'b1;
               branch_fire   = 1'b1;
            end else if (i_halt) begin
               o_pc_en      = 1'b0;
               o_ifid_flush = 1'b1;
               halt_acc     = 1'b1;
            end else if (i_stall_lu) begin
               o_pc_en       = 1'b0;
               o_ifid_en     = 1'b0;
               o_idex_bubble = 1'b1;
            end else if (i_imem_busy) begin
               o_pc_en      = 1'b0;
               o_ifid_flush = 1'b1;
            end
         end
         ST_DRAIN: begin
            o_pc_en      = 1'b0;
            o_ifid_flush = 1'b1;
            if (i_dmem_busy) begin
               o_idex_en     = 1'b0;
               o_exmm_en     = 1'b0;
               o_mmwb_bubble = 1'b1;
            end
         end
         default: begin
            o_pc_en   = 1'b0;
            o_ifid_en = 1'b0;
            o_idex_en = 1'b0;
            o_exmm_en = 1'b0;
            o_mmwb_en = 1'b0;
            o_halted  = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      drn_d   = drn_q;
      case (state_q)
         ST_RUN: begin
            if (halt_acc) begin
               state_d = ST_DRAIN;
               drn_d   = DRN_INIT;
            end
         end
         ST_DRAIN: begin
            // Drain only progresses while MM is actually retiring.
            if (!i_dmem_busy) begin
               if (drn_q <= DRN_W'(1)) begin
                  state_d = ST_HALTED;
                  drn_d   = '0;
               end else begin
                  drn_d = drn_q - DRN_W'(1);
               end
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_comb begin
      wd_d = '0;
      if (i_dmem_busy) begin
         wd_d = (wd_q >= WD_MAX) ? wd_q : wd_q + 16'd1;
      end
      timeout_d = timeout_q | (i_dmem_busy && (wd_d >= WD_MAX));

      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_RUN) && !o_pc_en) begin
         stall_cnt_d = stall_cnt_q + P_CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (branch_fire) begin
         flush_cnt_d = flush_cnt_q + P_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_RUN;
         drn_q       <= '0;
         wd_q        <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drn_q       <= drn_d;
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_timeout   = timeout_q;
   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table for RUN-state priority decode,
// plus hand-written watchdog, halt-drain and reset-from-HALTED sequences.
module tb_pipe_stall_ctrl;

   localparam int CW = 16;

   // Packed control order: pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmm_en, mmwb_en, mmwb_bubble
   localparam logic [7:0] C_IDLE   = 8'b11010110;
   localparam logic [7:0] C_STALL  = 8'b00011110;
   localparam logic [7:0] C_IMEM   = 8'b01110110;
   localparam logic [7:0] C_BR     = 8'b11111110;
   localparam logic [7:0] C_DMEM   = 8'b00000011;
   localparam logic [7:0] C_DRBUSY = 8'b01100011;
   localparam logic [7:0] C_NONE   = 8'b00000000;

   logic          clk;
   logic          rst;
   logic          stall_lu, branch, imem, dmem, halt;
   logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
   logic          exmm_en, mmwb_en, mmwb_bubble, halted, timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [7:0]    ctrl;

   int total = 0;
   int bad   = 0;

   pipe_stall_ctrl #(
      .P_CNT_W      (CW),
      .P_MEM_TIMEOUT(4),
      .P_DRAIN_CYC  (3)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall_lu    (stall_lu),
      .i_branch_taken(branch),
      .i_imem_busy   (imem),
      .i_dmem_busy   (dmem),
      .i_halt        (halt),
      .o_pc_en       (pc_en),
      .o_ifid_en     (ifid_en),
      .o_ifid_flush  (ifid_flush),
      .o_idex_en     (idex_en),
      .o_idex_bubble (idex_bubble),
      .o_exmm_en     (exmm_en),
      .o_mmwb_en     (mmwb_en),
      .o_mmwb_bubble (mmwb_bubble),
      .o_halted      (halted),
      .o_timeout     (timeout),
      .o_stall_cnt   (stall_cnt),
      .o_flush_cnt   (flush_cnt)
   );

   assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmm_en, mmwb_en, mmwb_bubble};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "time limit");
   end

   typedef struct {
      string      name;
      logic       sl, br, im, dm;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic sl, input logic br, input logic im, input logic dm, input logic ht);
      stall_lu = sl;
      branch   = br;
      imem     = im;
      dmem     = dm;
      halt     = ht;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_stall;
      int exp_flush;
      exp_stall = 0;
      exp_flush = 0;

      vecs[0] = '{"idle",          1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
      vecs[1] = '{"stall_lu",      1'b1, 1'b0, 1'b0, 1'b0, C_STALL};
      vecs[2] = '{"stall_lu_2",    1'b1, 1'b0, 1'b0, 1'b0, C_STALL};
      vecs[3] = '{"imem",          1'b0, 1'b0, 1'b1, 1'b0, C_IMEM};
      vecs[4] = '{"stall_imem",    1'b1, 1'b0, 1'b1, 1'b0, C_STALL};
      vecs[5] = '{"branch",        1'b0, 1'b1, 1'b0, 1'b0, C_BR};
      vecs[6] = '{"br_stall_imem", 1'b1, 1'b1, 1'b1, 1'b0, C_BR};
      vecs[7] = '{"dmem",          1'b0, 1'b0, 1'b0, 1'b1, C_DMEM};
      vecs[8] = '{"dmem_br",       1'b0, 1'b1, 1'b0, 1'b1, C_DMEM};
      vecs[9] = '{"dmem_all",      1'b1, 1'b1, 1'b1, 1'b1, C_DMEM};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;

      @(negedge clk);
      chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
      chk("reset_stall_cnt", 32'(stall_cnt), 0);
      chk("reset_flush_cnt", 32'(flush_cnt), 0);
      chk("reset_halted", 32'(halted), 0);
      chk("reset_timeout", 32'(timeout), 0);
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].sl, vecs[i].br, vecs[i].im, vecs[i].dm, 1'b0);
         @(negedge clk);
         chk({"vec_", vecs[i].name}, 32'(ctrl), 32'(vecs[i].exp));
         chk({"vec_halted_", vecs[i].name}, 32'(halted), 0);
         if (vecs[i].exp[7] == 1'b0) exp_stall++;
         if (vecs[i].br && !vecs[i].dm) exp_flush++;
         step();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      chk("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
      chk("table_timeout", 32'(timeout), 0);
      step();

      // Watchdog: timeout visible in the cycle after the 4th consecutive busy cycle.
      for (int k = 1; k <= 5; k++) begin
         drive(0, 0, 0, 1, 0);
         @(negedge clk);
         chk($sformatf("wd_ctrl_%0d", k), 32'(ctrl), 32'(C_DMEM));
         chk($sformatf("wd_timeout_%0d", k), 32'(timeout), (k == 5) ? 1 : 0);
         step();
      end
      exp_stall += 5;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("wd_sticky", 32'(timeout), 1);
      chk("wd_ctrl_after", 32'(ctrl), 32'(C_IDLE));
      chk("wd_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      step();

      // Halt pulse, one busy cycle during drain, halted at halt+5.
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("halt_cycle_ctrl", 32'(ctrl), 32'(C_IMEM));
      chk("halt_cycle_halted", 32'(halted), 0);
      step();
      exp_stall += 1;
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      chk("drain1_busy_ctrl", 32'(ctrl), 32'(C_DRBUSY));
      chk("drain1_halted", 32'(halted), 0);
      step();
      for (int k = 2; k <= 4; k++) begin
         drive(0, (k == 2) ? 1'b1 : 1'b0, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("drain%0d_ctrl", k), 32'(ctrl), 32'(C_IMEM));
         chk($sformatf("drain%0d_halted", k), 32'(halted), 0);
         step();
      end
      drive(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("halted_flag", 32'(halted), 1);
      chk("halted_ctrl_branch", 32'(ctrl), 32'(C_NONE));
      chk("halted_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      chk("halted_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
      step();
      drive(1, 0, 1, 0, 1);
      @(negedge clk);
      chk("halted_hold", 32'(halted), 1);
      chk("halted_hold_ctrl", 32'(ctrl), 32'(C_NONE));
      step();

      // Reset out of HALTED: reset cycle decodes as RUN, then counters clear.
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_cycle_ctrl", 32'(ctrl), 32'(C_IDLE));
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_halted", 32'(halted), 0);
      chk("post_rst_stall_cnt", 32'(stall_cnt), 0);
      chk("post_rst_flush_cnt", 32'(flush_cnt), 0);
      chk("post_rst_timeout", 32'(timeout), 0);
      chk("post_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
      step();
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_stall_ctrl", 32'(ctrl), 32'(C_STALL));
      step();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_stall_cnt1", 32'(stall_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Consumer side of the hazard/forwarding interface. Takes the load-use stall request and the other pipeline events (taken branch, instruction/data memory wait, halt), and turns them into per-stage register enables, flushes and bubbles for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MM, MM/WB). It also runs the halt-drain state machine, a memory-wait watchdog and the stall/flush performance counters.

Parameters:
P_CNT_W, 32, width of performance counters
P_MEM_TIMEOUT, 255, consecutive i_dmem_busy cycles before o_timeout sets (1..2^16-1)
P_DRAIN_CYC, 3, cycles to drain EX/MM/WB after halt

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  synchronous active-high reset
i_stall_lu  input  1  load-use stall request from the hazard unit (ID stage)
i_branch_taken  input  1  branch/jump resolved taken in EX
i_imem_busy  input  1  instruction fetch not ready this cycle
i_dmem_busy  input  1  data access in MM not complete this cycle
i_halt  input  1  halt/syscall decoded in ID (pulse)
o_pc_en  output  1  PC register load enable
o_ifid_en  output  1  IF/ID load enable
o_ifid_flush  output  1  IF/ID loads NOP (valid only with o_ifid_en=1)
o_idex_en  output  1  ID/EX load enable
o_idex_bubble  output  1  ID/EX loads NOP control
o_exmm_en  output  1  EX/MM load enable
o_mmwb_en  output  1  MM/WB load enable
o_mmwb_bubble  output  1  MM/WB loads NOP control
o_halted  output  1  pipeline fully drained and stopped
o_timeout  output  1  sticky data-memory watchdog flag
o_stall_cnt  output  P_CNT_W  cycles with o_pc_en=0 while in RUN
o_flush_cnt  output  P_CNT_W  cycles with o_ifid_flush=1 caused by a branch

Behaviour:
- States: RUN, DRAIN, HALTED. Reset -> RUN. All registers and counters clear. o_timeout=0, o_halted=0.
- Stage controls are combinational from state and inputs (zero latency). Counters and state update on the clock edge.
- RUN priority, highest first. Unlisted outputs: enables=1, flush/bubble=0.
  1. i_dmem_busy: pc_en=ifid_en=idex_en=exmm_en=0; mmwb_en=1, mmwb_bubble=1, so WB never repeats a write.
  2. i_branch_taken: pc_en=1, ifid_flush=1, idex_bubble=1. i_stall_lu and i_imem_busy are ignored because the ID instruction is squashed.
  3. i_stall_lu: pc_en=0, ifid_en=0, idex_bubble=1. This also covers a concurrent i_imem_busy.
  4. i_imem_busy: pc_en=0, ifid_flush=1.
- i_halt in RUN, accepted only when rule 1 and rule 2 are inactive: the same cycle behaves as rule 4 (pc_en=0, ifid_flush=1). The next state is DRAIN with the drain counter = P_DRAIN_CYC.
- DRAIN: pc_en=0, ifid_flush=1. Other stages follow rule 1 only.
  - The drain counter decrements when i_dmem_busy=0 and holds otherwise.
  - When the counter reaches 0 the next state is HALTED.
  - Branch, load-use, imem and halt inputs are ignored.
- HALTED: all enables=0, all flush/bubble=0, o_halted=1. Only i_rst exits.
- Watchdog:
  - Counts consecutive i_dmem_busy=1 cycles in any state and clears on i_dmem_busy=0.
  - When the count reaches P_MEM_TIMEOUT, o_timeout=1 from the next cycle.
  - The count saturates. o_timeout is sticky until reset and does not alter stage controls.
- o_stall_cnt increments each RUN cycle with o_pc_en=0. o_flush_cnt increments each cycle rule 2 fires. Both wrap modulo 2^P_CNT_W.
- Reset asserted mid-stall, mid-drain or in HALTED returns to RUN with counters cleared on that edge. Outputs during the reset cycle follow the current inputs in RUN priority.

Test Plan:
- Reset, then idle inputs -> all enables=1, flush/bubble=0, counters 0, o_halted=0.
- i_stall_lu=1 for 2 cycles -> pc_en=ifid_en=0, idex_bubble=1 each cycle; o_stall_cnt=2 afterwards.
- i_branch_taken=1 together with i_stall_lu=1 and i_imem_busy=1 -> pc_en=1, ifid_flush=1, idex_bubble=1; o_flush_cnt=1, o_stall_cnt unchanged.
- i_dmem_busy=1 with P_MEM_TIMEOUT=4 held for 5 cycles -> pc/ifid/idex/exmm enables=0, mmwb_bubble=1; o_timeout rises after the 4th busy cycle and stays 1 after busy drops.
- i_halt pulse, then i_dmem_busy=1 for 1 cycle during DRAIN -> o_halted=1 exactly P_DRAIN_CYC+2 cycles after the halt cycle; in HALTED, i_branch_taken=1 -> all enables remain 0.
- i_rst asserted in HALTED -> next cycle RUN, o_halted=0, counters 0.
